pc_sequencer: RTL

- Microcoded control sequencer for the 8-bit bench computer.
- Steps the fetch/execute T-state cycle and decodes the 4-bit opcode held in the instruction register.
- Each cycle it drives the control strobes of the 4-bit program counter (oe, inc, jmp) and of MAR, RAM, IR, A, B, ALU and OUT.
- Sits between the IR/flag register and every bus-attached block; it is the only driver of those control lines.

---
 rtl/pc_sequencer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Fetch/execute T-state sequencer for the 8-bit bench computer.
// Decodes the IR opcode into the per-cycle control strobes of every bus-attached block.
module pc_sequencer #(
    parameter bit         SKIP_UNUSED = 1'b1,
    parameter logic [3:0] OP_HLT      = 4'hF
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       run,
    input  logic [3:0] opcode,
    input  logic       flag_z,
    input  logic       flag_c,
    output logic       pc_oe,
    output logic       pc_inc,
    output logic       pc_jmp,
    output logic       mar_in,
    output logic       ram_oe,
    output logic       ram_we,
    output logic       ir_in,
    output logic       ir_oe,
    output logic       a_in,
    output logic       a_oe,
    output logic       b_in,
    output logic       alu_oe,
    output logic       alu_sub,
    output logic       out_in,
    output logic       halted,
    output logic [2:0] tstate
);

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;

    typedef enum logic [2:0] {
        ST_T0   = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    state_t state, state_nxt;
    logic   last;
    logic   s_pc_oe, s_pc_inc, s_pc_jmp, s_mar_in, s_ram_oe, s_ram_we, s_ir_in;
    logic   s_ir_oe, s_a_in, s_a_oe, s_b_in, s_alu_oe, s_alu_sub, s_out_in;
    logic   en;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= ST_T0;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        last      = 1'b0;
        s_pc_oe   = 1'b0;
        s_pc_inc  = 1'b0;
        s_pc_jmp  = 1'b0;
        s_mar_in  = 1'b0;
        s_ram_oe  = 1'b0;
        s_ram_we  = 1'b0;
        s_ir_in   = 1'b0;
        s_ir_oe   = 1'b0;
        s_a_in    = 1'b0;
        s_a_oe    = 1'b0;
        s_b_in    = 1'b0;
        s_alu_oe  = 1'b0;
        s_alu_sub = 1'b0;
        s_out_in  = 1'b0;
        case (state)
            ST_T0: begin
                s_pc_oe   = 1'b1;
                s_mar_in  = 1'b1;
                state_nxt = ST_T1;
            end
            ST_T1: begin
                s_ram_oe  = 1'b1;
                s_ir_in   = 1'b1;
                s_pc_inc  = 1'b1;
                state_nxt = ST_T2;
            end
            ST_T2: begin
                if (opcode == OP_HLT) begin
                    state_nxt = ST_HALT;
                end else begin
                    // Undefined opcodes fall through the default as NOP.
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            s_ir_oe  = 1'b1;
                            s_mar_in = 1'b1;
                        end
                        OP_LDI: begin
                            s_ir_oe = 1'b1;
                            s_a_in  = 1'b1;
                            last    = 1'b1;
                        end
                        OP_JMP: begin
                            s_ir_oe  = 1'b1;
                            s_pc_jmp = 1'b1;
                            last     = 1'b1;
                        end
                        OP_JC: begin
                            s_ir_oe  = flag_c;
                            s_pc_jmp = flag_c;
                            last     = 1'b1;
                        end
                        OP_JZ: begin
                            s_ir_oe  = flag_z;
                            s_pc_jmp = flag_z;
                            last     = 1'b1;
                        end
                        OP_OUT: begin
                            s_a_oe   = 1'b1;
                            s_out_in = 1'b1;
                            last     = 1'b1;
                        end
                        default: last = 1'b1;
                    endcase
                    state_nxt = (last && SKIP_UNUSED) ? ST_T0 : ST_T3;
                end
            end
            ST_T3: begin
                case (opcode)
                    OP_LDA: begin
                        s_ram_oe = 1'b1;
                        s_a_in   = 1'b1;
                        last     = 1'b1;
                    end
                    OP_STA: begin
                        s_a_oe   = 1'b1;
                        s_ram_we = 1'b1;
                        last     = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        s_ram_oe = 1'b1;
                        s_b_in   = 1'b1;
                    end
                    default: last = 1'b0;
                endcase
                state_nxt = (last && SKIP_UNUSED) ? ST_T0 : ST_T4;
            end
            ST_T4: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    s_alu_oe = 1'b1;
                    s_a_in   = 1'b1;
                end
                s_alu_sub = (opcode == OP_SUB);
                state_nxt = ST_T0;
            end
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_T0;
        endcase
        // A stalled cycle holds the step so its strobes fire exactly once on resume.
        if (!run) state_nxt = state;
    end

    assign en = run & ~clr;

    assign pc_oe   = s_pc_oe   & en;
    assign pc_inc  = s_pc_inc  & en;
    assign pc_jmp  = s_pc_jmp  & en;
    assign mar_in  = s_mar_in  & en;
    assign ram_oe  = s_ram_oe  & en;
    assign ram_we  = s_ram_we  & en;
    assign ir_in   = s_ir_in   & en;
    assign ir_oe   = s_ir_oe   & en;
    assign a_in    = s_a_in    & en;
    assign a_oe    = s_a_oe    & en;
    assign b_in    = s_b_in    & en;
    assign alu_oe  = s_alu_oe  & en;
    assign alu_sub = s_alu_sub & en;
    assign out_in  = s_out_in  & en;

    assign halted = (state == ST_HALT) & ~clr;

    always_comb begin
        tstate = 3'd0;
        if (!clr) begin
            case (state)
                ST_T0:   tstate = 3'd0;
                ST_T1:   tstate = 3'd1;
                ST_T2:   tstate = 3'd2;
                ST_T3:   tstate = 3'd3;
                ST_T4:   tstate = 3'd4;
                ST_HALT: tstate = 3'd4;
                default: tstate = 3'd0;
            endcase
        end
    end

endmodule
